// File: rtl/br_dir_pred_gshare_pkg.sv
// Shared types for the gshare direction predictor.
// Counter encoding, counter constants and the FSM state enum.
package br_dir_pred_gshare_pkg;

    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t CTR_SNT = 2'b00;
    localparam pht_ctr_t CTR_WNT = 2'b01;
    localparam pht_ctr_t CTR_WT  = 2'b10;
    localparam pht_ctr_t CTR_ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/br_dir_pred_gshare_sat_ctr2.sv
// 2-bit saturating counter update for the commit path.
// Ports: ctr (current), taken (resolved), ctr_nxt (updated).
module sat_ctr2
    import br_dir_pred_gshare_pkg::*;
(
    input  pht_ctr_t ctr,
    input  logic     taken,
    output pht_ctr_t ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_nxt = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/br_dir_pred_gshare.sv
// Gshare direction predictor: FETCH_W slots per block, speculative GHR
// with commit-time recovery, PHT cleared by a post-reset sweep.
// Ports: clock, reset (sync, active-low); pred_* fetch-side request and
// per-slot prediction; cm_* resolved-branch commit and recovery.
// Optional: define BR_PRED_STAT_EN for stat_pred_cnt / stat_mispred_cnt.
module br_dir_pred_gshare
    import br_dir_pred_gshare_pkg::*;
#(
    parameter int       FETCH_W  = 4,
    parameter int       SLOT_W   = $clog2(FETCH_W),
    parameter int       GHR_W    = 6,
    parameter int       IDX_W    = 6,
    parameter pht_ctr_t CTR_INIT = 2'b01
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pred_valid,
    input  logic [31:0]        pred_pc,
    input  logic [FETCH_W-1:0] pred_is_br,
    output logic               pred_ready,
    output logic [FETCH_W-1:0] pred_taken,
    output logic               pred_any,
    output logic [SLOT_W-1:0]  pred_first,
    output logic [GHR_W-1:0]   pred_ghr,
`ifdef BR_PRED_STAT_EN
    output logic [31:0]        stat_pred_cnt,
    output logic [31:0]        stat_mispred_cnt,
`endif
    input  logic               cm_valid,
    input  logic [31:0]        cm_pc,
    input  logic [GHR_W-1:0]   cm_ghr,
    input  logic               cm_taken,
    input  logic               cm_mispred,
    output logic               cm_ready
);

    localparam int DEPTH = 1 << IDX_W;

    typedef pht_ctr_t [FETCH_W-1:0] pht_row_t;

    fsm_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    pht_row_t         pht_q [DEPTH];

    logic               run;
    logic               pred_acc;
    logic [IDX_W-1:0]   pred_idx;
    logic [SLOT_W-1:0]  pred_off;
    pht_row_t           pred_row;
    logic [FETCH_W-1:0] slot_mask;
    logic [FETCH_W-1:0] br_mask;
    logic [FETCH_W-1:0] taken_w;
    logic [SLOT_W-1:0]  first_w;

    logic              cm_acc;
    logic [IDX_W-1:0]  cm_idx;
    logic [SLOT_W-1:0] cm_slot;
    pht_row_t          cm_row;
    pht_ctr_t          cm_ctr_old;
    pht_ctr_t          cm_ctr_new;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    pht_row_t          wr_row;

    assign run = (state_q == ST_RUN);

    // Sweep FSM
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            ST_INIT: begin
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (&sweep_idx_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Prediction path
    always_comb begin
        pred_acc  = pred_valid & run;
        pred_idx  = pred_pc[2+SLOT_W +: IDX_W] ^ IDX_W'(ghr_q);
        pred_off  = pred_pc[2 +: SLOT_W];
        pred_row  = pht_q[pred_idx];
        slot_mask = '0;
        taken_w   = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            slot_mask[i] = (SLOT_W'(i) >= pred_off);
        end
        br_mask = pred_is_br & slot_mask;
        for (int i = 0; i < FETCH_W; i++) begin
            taken_w[i] = pred_row[i][1] & br_mask[i] & pred_acc;
        end
        first_w = '0;
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            if (taken_w[i]) begin
                first_w = SLOT_W'(i);
            end
        end
    end

    // Commit path
    always_comb begin
        cm_acc     = cm_valid & run;
        cm_idx     = cm_pc[2+SLOT_W +: IDX_W] ^ IDX_W'(cm_ghr);
        cm_slot    = cm_pc[2 +: SLOT_W];
        cm_row     = pht_q[cm_idx];
        cm_ctr_old = cm_row[cm_slot];
    end

    sat_ctr2 u_sat_ctr2 (
        .ctr     (cm_ctr_old),
        .taken   (cm_taken),
        .ctr_nxt (cm_ctr_new)
    );

    // Single PHT write port: sweep during INIT, commit during RUN
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = sweep_idx_q;
        wr_row = {FETCH_W{CTR_INIT}};
        if (!run) begin
            wr_en = 1'b1;
        end else if (cm_acc) begin
            wr_en           = 1'b1;
            wr_idx          = cm_idx;
            wr_row          = cm_row;
            wr_row[cm_slot] = cm_ctr_new;
        end
    end

    // Recovery overrides the speculative shift; one bit per block
    always_comb begin
        ghr_d = ghr_q;
        if (cm_acc && cm_mispred) begin
            ghr_d = {cm_ghr[GHR_W-2:0], cm_taken};
        end else if (pred_acc) begin
            if (|taken_w) begin
                ghr_d = {ghr_q[GHR_W-2:0], 1'b1};
            end else if (|br_mask) begin
                ghr_d = {ghr_q[GHR_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= '0;
            ghr_q       <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            ghr_q       <= ghr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            pht_q[wr_idx] <= wr_row;
        end
    end

`ifdef BR_PRED_STAT_EN
    logic [31:0] stat_pred_q, stat_pred_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_pred_d = stat_pred_q;
        stat_mis_d  = stat_mis_q;
        if (pred_acc && (|taken_w) && !(&stat_pred_q)) begin
            stat_pred_d = stat_pred_q + 32'd1;
        end
        if (cm_acc && cm_mispred && !(&stat_mis_q)) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_pred_q <= '0;
            stat_mis_q  <= '0;
        end else begin
            stat_pred_q <= stat_pred_d;
            stat_mis_q  <= stat_mis_d;
        end
    end

    assign stat_pred_cnt    = stat_pred_q;
    assign stat_mispred_cnt = stat_mis_q;
`endif

    assign pred_ready = run;
    assign cm_ready   = run;
    assign pred_taken = taken_w;
    assign pred_any   = |taken_w;
    assign pred_first = first_w;
    assign pred_ghr   = ghr_q;

endmodule

// File: tb/tb_br_dir_pred_gshare.sv
// Directed bench for br_dir_pred_gshare (FETCH_W=4, GHR_W=4, IDX_W=5).
// Sweep timing sequences by hand, then a per-cycle vector table.
module tb_br_dir_pred_gshare;

    logic        clock;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic [3:0]  pred_is_br;
    logic        pred_ready;
    logic [3:0]  pred_taken;
    logic        pred_any;
    logic [1:0]  pred_first;
    logic [3:0]  pred_ghr;
    logic        cm_valid;
    logic [31:0] cm_pc;
    logic [3:0]  cm_ghr;
    logic        cm_taken;
    logic        cm_mispred;
    logic        cm_ready;
`ifdef BR_PRED_STAT_EN
    logic [31:0] stat_pred_cnt;
    logic [31:0] stat_mispred_cnt;
`endif

    br_dir_pred_gshare #(
        .FETCH_W (4),
        .GHR_W   (4),
        .IDX_W   (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_pc    (pred_pc),
        .pred_is_br (pred_is_br),
        .pred_ready (pred_ready),
        .pred_taken (pred_taken),
        .pred_any   (pred_any),
        .pred_first (pred_first),
        .pred_ghr   (pred_ghr),
`ifdef BR_PRED_STAT_EN
        .stat_pred_cnt    (stat_pred_cnt),
        .stat_mispred_cnt (stat_mispred_cnt),
`endif
        .cm_valid   (cm_valid),
        .cm_pc      (cm_pc),
        .cm_ghr     (cm_ghr),
        .cm_taken   (cm_taken),
        .cm_mispred (cm_mispred),
        .cm_ready   (cm_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic [3:0]  br;
        logic        cv;
        logic [31:0] cpc;
        logic [3:0]  cghr;
        logic        ct;
        logic        cm;
        logic [3:0]  e_tk;
        logic [1:0]  e_first;
        logic [3:0]  e_ghr;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    initial begin
        int n;

        // pv pc br | cv cpc cghr ct cm | taken first ghr(this cycle)
        vt[0]  = '{1, 32'h2A4, 4'hF, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'h0};
        vt[1]  = '{1, 32'h100, 4'h1, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'h0};
        vt[2]  = '{0, 32'h0,   4'h0, 1, 32'h100, 4'h0, 1, 0, 4'h0, 2'd0, 4'h0};
        vt[3]  = '{0, 32'h0,   4'h0, 1, 32'h100, 4'h0, 1, 0, 4'h0, 2'd0, 4'h0};
        vt[4]  = '{0, 32'h0,   4'h0, 1, 32'h10C, 4'h0, 1, 0, 4'h0, 2'd0, 4'h0};
        vt[5]  = '{0, 32'h0,   4'h0, 1, 32'h10C, 4'h0, 1, 0, 4'h0, 2'd0, 4'h0};
        vt[6]  = '{1, 32'h100, 4'h1, 0, 32'h0,   4'h0, 0, 0, 4'h1, 2'd0, 4'h0};
        vt[7]  = '{0, 32'h0,   4'h0, 1, 32'h3F0, 4'h0, 0, 1, 4'h0, 2'd0, 4'h1};
        vt[8]  = '{1, 32'h108, 4'h1, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'h0};
        vt[9]  = '{1, 32'h104, 4'h9, 0, 32'h0,   4'h0, 0, 0, 4'h8, 2'd3, 4'h0};
        vt[10] = '{0, 32'h0,   4'h0, 1, 32'h3F0, 4'h5, 1, 1, 4'h0, 2'd0, 4'h1};
        vt[11] = '{1, 32'h1B0, 4'h1, 1, 32'h000, 4'h6, 0, 1, 4'h1, 2'd0, 4'hB};
        vt[12] = '{1, 32'h000, 4'h2, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'hC};
        vt[13] = '{1, 32'h000, 4'h0, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'h8};
        vt[14] = '{0, 32'h180, 4'h1, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'h8};
        vt[15] = '{0, 32'h0,   4'h0, 1, 32'h050, 4'h0, 0, 0, 4'h0, 2'd0, 4'h8};
        vt[16] = '{0, 32'h0,   4'h0, 1, 32'h050, 4'h0, 0, 0, 4'h0, 2'd0, 4'h8};
        vt[17] = '{0, 32'h0,   4'h0, 1, 32'h050, 4'h0, 0, 0, 4'h0, 2'd0, 4'h8};
        vt[18] = '{1, 32'h0D0, 4'h1, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'h8};
        vt[19] = '{1, 32'h050, 4'h1, 1, 32'h050, 4'h0, 1, 0, 4'h0, 2'd0, 4'h0};
        vt[20] = '{1, 32'h050, 4'h1, 1, 32'h050, 4'h0, 1, 0, 4'h0, 2'd0, 4'h0};
        vt[21] = '{1, 32'h050, 4'h1, 0, 32'h0,   4'h0, 0, 0, 4'h1, 2'd0, 4'h0};
        vt[22] = '{0, 32'h0,   4'h0, 0, 32'h0,   4'h0, 0, 0, 4'h0, 2'd0, 4'h1};

        // Hostile traffic held through reset and sweep: must be ignored
        reset      = 1'b0;
        pred_valid = 1'b1;
        pred_pc    = 32'h100;
        pred_is_br = 4'hF;
        cm_valid   = 1'b1;
        cm_pc      = 32'h100;
        cm_ghr     = 4'h0;
        cm_taken   = 1'b1;
        cm_mispred = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 32'(pred_ready), 32'd0);
        chk("rst_cm_ready", 32'(cm_ready), 32'd0);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_any", 32'(pred_any), 32'd0);
        chk("rst_first", 32'(pred_first), 32'd0);
        chk("rst_ghr", 32'(pred_ghr), 32'd0);

        // Interrupted sweep: reset again at sweep cycle 10
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("sweep1_ready_c%0d", c), 32'(pred_ready), 32'd0);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_ready", 32'(pred_ready), 32'd0);
        chk("midrst_ghr", 32'(pred_ghr), 32'd0);
        reset = 1'b1;

        // Full sweep must take exactly 32 cycles
        n = 0;
        while (!pred_ready && n < 100) begin
            chk($sformatf("init_taken_c%0d", n), 32'(pred_taken), 32'd0);
            @(posedge clock);
            #1;
            n++;
        end
        chk("sweep_len", 32'(n), 32'd32);
        pred_valid = 1'b0;
        cm_valid   = 1'b0;
        cm_mispred = 1'b0;
        chk("init_ghr", 32'(pred_ghr), 32'd0);
        chk("run_cm_ready", 32'(cm_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            pred_valid = vt[i].pv;
            pred_pc    = vt[i].pc;
            pred_is_br = vt[i].br;
            cm_valid   = vt[i].cv;
            cm_pc      = vt[i].cpc;
            cm_ghr     = vt[i].cghr;
            cm_taken   = vt[i].ct;
            cm_mispred = vt[i].cm;
            #1;
            chk($sformatf("r%0d_ready", i), 32'(pred_ready), 32'd1);
            chk($sformatf("r%0d_taken", i), 32'(pred_taken),
                32'(vt[i].e_tk));
            chk($sformatf("r%0d_any", i), 32'(pred_any),
                32'(vt[i].e_tk != 4'h0));
            chk($sformatf("r%0d_first", i), 32'(pred_first),
                32'(vt[i].e_first));
            chk($sformatf("r%0d_ghr", i), 32'(pred_ghr),
                32'(vt[i].e_ghr));
            @(posedge clock);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_dir_pred_gshare.md
Name: br_dir_pred_gshare

Overview:
- Parametrised gshare direction predictor. Successor to the fixed 4-slot, per-PC-BHR direction logic.
- Predicts FETCH_W instruction slots per fetch block.
- Keeps a speculative global history register (GHR) with snapshot and mispredict recovery.
- Clears its pattern table with a post-reset sweep FSM.
- Sits beside the BTB/RAS in the fetch stage. The BTB supplies per-slot branch hints; commit writes back resolved outcomes.

Parameters:
- FETCH_W, 4: instruction slots per fetch block; power of two, 2..8.
- SLOT_W, $clog2(FETCH_W): slot index width (derived).
- GHR_W, 6: global history length in bits.
- IDX_W, 6: PHT index width; PHT depth is 2**IDX_W entries. Requires IDX_W >= GHR_W.
- CTR_INIT, 2'b01: counter value written by the init sweep (weakly not-taken).

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-low reset.
- pred_valid, input, 1: fetch presents a block this cycle.
- pred_pc, input, 32: fetch PC; slot offset is pred_pc[2+:SLOT_W].
- pred_is_br, input, FETCH_W: BTB hint, bit i set when slot i is a conditional branch.
- pred_ready, output, 1: predictor is in RUN.
- pred_taken, output, FETCH_W: per-slot taken prediction.
- pred_any, output, 1: OR of pred_taken.
- pred_first, output, SLOT_W: lowest set slot of pred_taken; 0 when none is set.
- pred_ghr, output, GHR_W: GHR value used for this prediction, carried to commit.
- cm_valid, input, 1: a resolved conditional branch is committing.
- cm_pc, input, 32: committing branch PC.
- cm_ghr, input, GHR_W: snapshot returned with the branch.
- cm_taken, input, 1: resolved direction.
- cm_mispred, input, 1: direction was mispredicted.
- cm_ready, output, 1: commit accepted; equals pred_ready.

Behaviour:
- FSM states: INIT and RUN.
  - While reset is low: state = INIT, sweep index = 0, GHR = 0.
  - INIT: write {FETCH_W{CTR_INIT}} to PHT[index] each cycle and increment the index. At index 2**IDX_W-1, move to RUN next cycle. Sweep length is exactly 2**IDX_W cycles after reset deasserts.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- Outputs during INIT and reset: pred_ready = cm_ready = 0, pred_taken = 0, pred_any = 0, pred_first = 0. pred_ghr shows GHR, which is 0.
- PHT index: pred_pc[(2+SLOT_W)+:IDX_W] XOR zero-extended GHR.
- PHT read: combinational, same cycle as pred_valid; each entry holds FETCH_W 2-bit counters.
- Per-slot prediction: pred_taken[i] = ctr[i][1] & pred_is_br[i] & (i >= offset) & pred_valid & pred_ready.
- Speculative GHR update, on pred_valid & pred_ready, when the cycle has no recovery:
  - pred_any = 1: GHR <= {GHR[GHR_W-2:0], 1}.
  - Else, if any masked pred_is_br bit is set: GHR <= {GHR[GHR_W-2:0], 0}.
  - Else: GHR unchanged.
  - Only one history bit is shifted per block.
- Commit (cm_valid & cm_ready):
  - Index = cm_pc[(2+SLOT_W)+:IDX_W] XOR cm_ghr; slot = cm_pc[2+:SLOT_W].
  - Update only that slot's counter: saturating +1 if taken (11 stays 11), -1 if not taken (00 stays 00).
  - The write is visible the next cycle. A same-cycle read of the same index returns the old value.
- Recovery: cm_valid & cm_ready & cm_mispred sets GHR <= {cm_ghr[GHR_W-2:0], cm_taken}.
  - Recovery has priority over a same-cycle speculative update, which is dropped.
  - That cycle's prediction outputs remain valid, computed from the pre-recovery GHR.
- cm_valid while cm_ready = 0 is ignored; the caller holds it.

Optional Feature:
- Macro: BR_PRED_STAT_EN.
- Defined: adds 32-bit outputs stat_pred_cnt (accepted blocks with pred_any) and stat_mispred_cnt (accepted commits with cm_mispred).
  - Both clear on reset and saturate at 0xFFFFFFFF.
  - Both hold their value during INIT.
- Undefined: these ports and counters do not exist, with no other change.

Decomposition:
- Shared package (struct.sv): typedef pht_ctr_t (logic [1:0]), constants CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11, and an enum for the FSM states.
- One sub-module, sat_ctr2: 2-bit saturating update with inputs ctr and taken and output next value. Instantiated once in the commit path.
- PHT array, FSM, GHR and first-one search stay in the top level.

Test Plan:
All scenarios use FETCH_W=4, GHR_W=4, IDX_W=5.
1. Reset low 3 cycles, then high → pred_ready = 0 for exactly 32 cycles, then 1. Any PC with pred_is_br = 4'b1111 gives pred_taken = 0000.
2. Reset low at sweep cycle 10 → after release, pred_ready stays low a full 32 cycles.
3. Commit twice, cm_pc = 0x100 (slot 0), cm_ghr = 0, taken, no mispred → counter 01→10→11. Then, with GHR = 0, pred_pc = 0x100 and pred_is_br = 0001 → pred_taken = 0001, pred_first = 0, and GHR becomes 0001 next cycle.
4. With the trained counter from scenario 3 (PHT index at pred_pc 0x108 and GHR = 0 has slot 0 = 11), present pred_pc = 0x108 (offset 2), pred_is_br = 0001 → pred_taken = 0000, and GHR is unchanged.
5. GHR = 1011 with a same-cycle accepted prediction (pred_any = 1) and a commit carrying mispred, cm_ghr = 0110, cm_taken = 0 → GHR = 1100 next cycle; the speculative shift is dropped.
6. Three not-taken commits to a counter at 01 → counter reads 00 and stays 00; the predicted slot gives pred_taken = 0.
